// File: rtl/rvv_xrf_wb_arb_pkg.sv
// Shared RVV scalar-writeback definitions: retire-slot count, default buffer depth
// and the writeback record that connects directly to RT2XRF_t consumers.
package rvv_xrf_wb_arb_pkg;

   localparam int unsigned NUM_RT_UOP   = 2;
   localparam int unsigned XRF_WB_DEPTH = 4;

   typedef logic [31:0] xrf_data_t;
   typedef logic [4:0]  xrf_addr_t;

   typedef struct packed {
      xrf_addr_t rt_index;
      xrf_data_t rt_data;
   } XRF_WB_t;

endpackage

// File: rtl/rvv_mw_fifo.sv
// Generic N-write / 1-read compacting circular FIFO. Pushed slots land at consecutive
// entries from wptr in ascending slot order; space_o is a prefix mask from the registered count.
module rvv_mw_fifo
   import rvv_xrf_wb_arb_pkg::*;
#(
   parameter int unsigned NUM_W = NUM_RT_UOP,
   parameter int unsigned DEPTH = XRF_WB_DEPTH,
   parameter type         T     = XRF_WB_t
)(
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NUM_W-1:0]           push_i,
   input  T                           wdata_i [NUM_W],
   output logic [NUM_W-1:0]           space_o,
   input  logic                       pop_i,
   output logic                       valid_o,
   output T                           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   T              mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d, enq_n;
   logic [PW-1:0] slot_off [NUM_W];
   logic          deq;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_W; gi++) begin : g_space
         assign space_o[gi] = (DEPTH - 32'(count_q)) > gi;
      end
   endgenerate

   // Running prefix count gives each pushed slot its offset from wptr.
   always_comb begin
      enq_n = '0;
      for (int i = 0; i < NUM_W; i++) begin
         slot_off[i] = enq_n[PW-1:0];
         enq_n       = enq_n + CW'(push_i[i]);
      end
   end

   assign valid_o = (count_q != '0);
   assign deq     = pop_i && valid_o;
   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

   assign count_d = count_q + enq_n - CW'(deq);
   assign wptr_d  = wptr_q + enq_n[PW-1:0];
   assign rptr_d  = rptr_q + PW'(deq);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         for (int i = 0; i < NUM_W; i++) begin
            if (push_i[i]) mem_q[wptr_q + slot_off[i]] <= wdata_i[i];
         end
      end
   end

endmodule

// File: rtl/rvv_xrf_wb_arb.sv
// Scalar-regfile writeback arbiter: buffers retire-slot writebacks in age order and drains
// one per cycle. Define RVV_XRF_WB_BYPASS_EN for a zero-latency path when the buffer is empty.
module rvv_xrf_wb_arb
   import rvv_xrf_wb_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS = NUM_RT_UOP,
   parameter int unsigned DEPTH     = XRF_WB_DEPTH,
   parameter type         RegDataT  = logic [31:0],
   parameter type         RegAddrT  = logic [4:0]
)(
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NUM_PORTS-1:0]       in_valid,
   input  RegAddrT                    in_addr [NUM_PORTS],
   input  RegDataT                    in_data [NUM_PORTS],
   output logic [NUM_PORTS-1:0]       in_ready,
   output logic                       out_valid,
   output RegAddrT                    out_addr,
   output RegDataT                    out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       idle
);

   typedef struct packed {
      RegAddrT rt_index;
      RegDataT rt_data;
   } wb_t;

   wb_t                  wdata [NUM_PORTS];
   wb_t                  fifo_head, head;
   logic [NUM_PORTS-1:0] nonzero, accept, push;
   logic                 fifo_valid;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
         assign wdata[gi]   = '{rt_index: in_addr[gi], rt_data: in_data[gi]};
         assign nonzero[gi] = (in_addr[gi] != '0);
      end
   endgenerate

   // x0 writes complete the handshake but never reach the buffer.
   assign accept = in_valid & in_ready;

`ifdef RVV_XRF_WB_BYPASS_EN
   logic [NUM_PORTS-1:0] byp_cand, byp_take;
   logic                 byp_hit;
   wb_t                  byp_ent;

   // Descending scan so the oldest eligible slot is the one left selected.
   always_comb begin
      byp_cand = '0;
      byp_ent  = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (in_valid[i] && nonzero[i]) begin
            byp_cand    = '0;
            byp_cand[i] = 1'b1;
            byp_ent     = wdata[i];
         end
      end
   end

   assign byp_hit   = (count == '0) && (byp_cand != '0);
   assign byp_take  = byp_cand & {NUM_PORTS{byp_hit && out_ready}};
   assign push      = accept & nonzero & ~byp_take;
   assign out_valid = fifo_valid || byp_hit;
   assign head      = fifo_valid ? fifo_head : byp_ent;
`else
   assign push      = accept & nonzero;
   assign out_valid = fifo_valid;
   assign head      = fifo_head;
`endif

   assign out_addr = head.rt_index;
   assign out_data = head.rt_data;
   assign idle     = (count == '0) && !(|in_valid);

   rvv_mw_fifo #(
      .NUM_W (NUM_PORTS),
      .DEPTH (DEPTH),
      .T     (wb_t)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push),
      .wdata_i (wdata),
      .space_o (in_ready),
      .pop_i   (out_ready),
      .valid_o (fifo_valid),
      .rdata_o (fifo_head),
      .count_o (count)
   );

endmodule
